// File: rtl/common_dffcam_ctrl_pkg.sv
// Shared types for the DFF-CAM sequencing controller: FSM state encoding and op codes.
package common_dffcam_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_REMOVE = 1'b1;

endpackage

// File: rtl/common_dffcam_ctrl_freesel.sv
// Lowest-index free entry finder: priority encoder over the inverted occupancy bitmap.
module common_dffcam_ctrl_freesel #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] occ,
    output logic [AW-1:0]    free_idx,
    output logic             any_free
);

    // Scan high to low so the last assignment wins with the lowest free index.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                free_idx = AW'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/common_dffcam_ctrl_1q1w.sv
// Insert/remove sequencer for one DFF CAM; owns the occupancy bitmap.
// Define COMMON_DFFCAM_CTRL_REPLACE_EN for round-robin eviction when the table is full.
module common_dffcam_ctrl_1q1w
    import common_dffcam_ctrl_pkg::*;
#(
    parameter  int CAM_DEPTH = 8,
    parameter  int CAM_WIDTH = 8,
    localparam int AW        = $clog2(CAM_DEPTH),
    localparam int CW        = $clog2(CAM_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [CAM_WIDTH-1:0] req_key,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [AW-1:0]        rsp_addr,
    output logic                 rsp_hit,
    output logic                 rsp_full,
    output logic [CW-1:0]        count,
    output logic [AW-1:0]        cam_addr,
    output logic                 cam_en,
    output logic                 cam_we,
    output logic [CAM_WIDTH-1:0] cam_din,
    output logic                 cam_din_valid,
    output logic [CAM_WIDTH-1:0] cam_qdata,
    input  logic [AW-1:0]        cam_qaddr,
    input  logic                 cam_qvalid
);

    state_e                 state_q, state_d;
    logic                   op_q, op_d;
    logic [CAM_WIDTH-1:0]   key_q, key_d;
    logic [CAM_DEPTH-1:0]   occ_q, occ_d;
    logic                   wr_q, wr_d;
    logic [AW-1:0]          waddr_q, waddr_d;
    logic                   wvalid_q, wvalid_d;
    logic [AW-1:0]          rsp_addr_q, rsp_addr_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic                   rsp_full_q, rsp_full_d;
    logic [AW-1:0]          free_idx;
    logic                   any_free;
`ifdef COMMON_DFFCAM_CTRL_REPLACE_EN
    logic [AW-1:0]          victim_q, victim_d;
`endif

    common_dffcam_ctrl_freesel #(
        .DEPTH (CAM_DEPTH),
        .AW    (AW)
    ) u_freesel (
        .occ      (occ_q),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        key_d      = key_q;
        occ_d      = occ_q;
        wr_d       = wr_q;
        waddr_d    = waddr_q;
        wvalid_d   = wvalid_q;
        rsp_addr_d = rsp_addr_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_full_d = rsp_full_q;
`ifdef COMMON_DFFCAM_CTRL_REPLACE_EN
        victim_d   = victim_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    key_d   = req_key;
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                state_d    = ST_WRITE;
                wr_d       = 1'b0;
                wvalid_d   = 1'b0;
                rsp_hit_d  = cam_qvalid;
                rsp_full_d = 1'b0;
                rsp_addr_d = '0;
                if (op_q == OP_INSERT) begin
                    if (cam_qvalid) begin
                        rsp_addr_d = cam_qaddr;
                    end else if (any_free) begin
                        wr_d       = 1'b1;
                        wvalid_d   = 1'b1;
                        waddr_d    = free_idx;
                        rsp_addr_d = free_idx;
                    end else begin
`ifdef COMMON_DFFCAM_CTRL_REPLACE_EN
                        wr_d       = 1'b1;
                        wvalid_d   = 1'b1;
                        waddr_d    = victim_q;
                        rsp_addr_d = victim_q;
                        victim_d   = (victim_q == AW'(CAM_DEPTH - 1)) ? '0 : victim_q + 1'b1;
`else
                        rsp_full_d = 1'b1;
`endif
                    end
                end else if (cam_qvalid) begin
                    wr_d       = 1'b1;
                    wvalid_d   = 1'b0;
                    waddr_d    = cam_qaddr;
                    rsp_addr_d = cam_qaddr;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
                // Bitmap tracks what the CAM latches on this same edge.
                if (wr_q) occ_d[waddr_q] = wvalid_q;
            end
            default: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_INSERT;
            key_q      <= '0;
            occ_q      <= '0;
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            wvalid_q   <= 1'b0;
            rsp_addr_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            key_q      <= key_d;
            occ_q      <= occ_d;
            wr_q       <= wr_d;
            waddr_q    <= waddr_d;
            wvalid_q   <= wvalid_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_full_q <= rsp_full_d;
        end
    end

`ifdef COMMON_DFFCAM_CTRL_REPLACE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) victim_q <= '0;
        else       victim_q <= victim_d;
    end
`endif

    always_comb begin
        count = '0;
        for (int i = 0; i < CAM_DEPTH; i++) count = count + CW'(occ_q[i]);
    end

    // cam_en decodes from state so an async reset kills it in the same cycle.
    assign cam_en        = (state_q == ST_WRITE) && wr_q;
    assign cam_we        = cam_en;
    assign cam_addr      = waddr_q;
    assign cam_din       = key_q;
    assign cam_din_valid = wvalid_q;
    assign cam_qdata     = key_q;
    assign req_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_addr      = rsp_addr_q;
    assign rsp_hit       = rsp_hit_q;
    assign rsp_full      = rsp_full_q;

endmodule

// File: tb/tb_common_dffcam_ctrl_1q1w.sv
// Bench for common_dffcam_ctrl_1q1w: behavioural CAM attached, key-table reference model.
module tb_common_dffcam_ctrl_1q1w;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_op;
    logic [7:0] req_key;
    logic       rsp_valid, rsp_ready, rsp_hit, rsp_full;
    logic [2:0] rsp_addr, cam_addr, cam_qaddr;
    logic [3:0] count;
    logic       cam_en, cam_we, cam_din_valid, cam_qvalid;
    logic [7:0] cam_din, cam_qdata;

    common_dffcam_ctrl_1q1w #(.CAM_DEPTH(D), .CAM_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_hit(rsp_hit), .rsp_full(rsp_full), .count(count),
        .cam_addr(cam_addr), .cam_en(cam_en), .cam_we(cam_we), .cam_din(cam_din),
        .cam_din_valid(cam_din_valid), .cam_qdata(cam_qdata),
        .cam_qaddr(cam_qaddr), .cam_qvalid(cam_qvalid)
    );

    always #5 clk = ~clk;

    // Attached CAM: registered write port, combinational query.
    logic [7:0] ck [D];
    logic [D-1:0] cv;
    always @(posedge clk or posedge reset) begin
        if (reset) cv <= '0;
        else if (cam_en && cam_we) begin
            ck[cam_addr] <= cam_din;
            cv[cam_addr] <= cam_din_valid;
        end
    end
    always_comb begin
        cam_qvalid = 1'b0;
        cam_qaddr  = '0;
        for (int i = D - 1; i >= 0; i--)
            if (cv[i] && ck[i] == cam_qdata) begin
                cam_qvalid = 1'b1;
                cam_qaddr  = 3'(i);
            end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: which key sits in which slot, plus the eviction cursor.
    logic [7:0] mkey [D];
    bit         mval [D];
    int         mvict;

    task automatic model_reset();
        for (int i = 0; i < D; i++) mval[i] = 0;
        mvict = 0;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += mval[i];
        return n;
    endfunction

    logic [2:0] last_addr;
    logic       last_hit, last_full;

    task automatic do_op(input logic op, input logic [7:0] key, input int hold);
        int slot = -1, fr = -1, lat = 0, pulses = 0;
        bit e_hit = 0, e_full = 0, e_wr = 0, e_dv = 0, busy_bad = 0;
        int e_addr = 0;
        logic [2:0] waddr = '0;
        logic       wdv = 1'b0;
        logic [7:0] wdin = '0;
        logic [2:0] s_addr;
        logic       s_hit, s_full;
        for (int i = 0; i < D; i++) if (mval[i] && mkey[i] == key && slot < 0) slot = i;
        for (int i = 0; i < D; i++) if (!mval[i] && fr < 0) fr = i;
        e_hit = (slot >= 0);
        if (op == 1'b0) begin
            if (e_hit) e_addr = slot;
            else if (fr >= 0) begin e_wr = 1; e_dv = 1; e_addr = fr; mkey[fr] = key; mval[fr] = 1; end
            else begin
`ifdef COMMON_DFFCAM_CTRL_REPLACE_EN
                e_wr = 1; e_dv = 1; e_addr = mvict; mkey[mvict] = key; mvict = (mvict + 1) % D;
`else
                e_full = 1;
`endif
            end
        end else if (e_hit) begin
            e_wr = 1; e_addr = slot; mval[slot] = 0;
        end

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_key = key;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_key = 8'($urandom);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (req_ready) busy_bad = 1;
            if (lat == 1) chk("qdata", cam_qdata, key);
            if (cam_en) begin
                pulses++; waddr = cam_addr; wdv = cam_din_valid; wdin = cam_din;
                chk("cam_we", cam_we, 1);
                chk("wr_cycle", lat, 2);
            end
        end
        chk("latency", lat, 3);
        chk("busy_ready", busy_bad, 0);
        chk("en_pulses", pulses, e_wr);
        if (e_wr) begin
            chk("wr_addr", waddr, e_addr);
            chk("wr_dv", wdv, e_dv);
            chk("wr_din", wdin, key);
        end
        chk("rsp_addr", rsp_addr, e_addr);
        chk("rsp_hit", rsp_hit, e_hit);
        chk("rsp_full", rsp_full, e_full);
        chk("count", count, model_count());
        s_addr = rsp_addr; s_hit = rsp_hit; s_full = rsp_full;
        last_addr = rsp_addr; last_hit = rsp_hit; last_full = rsp_full;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_ready", req_ready, 0);
            chk("hold_rsp", {rsp_addr, rsp_hit, rsp_full}, {s_addr, s_hit, s_full});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("back_idle", {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_key = '0; rsp_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_outs", {rsp_valid, rsp_hit, rsp_full, cam_en, cam_din_valid}, 5'b0);
        chk("rst_vals", {rsp_addr, cam_addr, cam_din, cam_qdata, count}, 26'b0);
        @(negedge clk); reset = 1'b0;

        do_op(1'b0, 8'h5A, 0);
        chk("first_ins", {last_hit, last_addr}, 4'b0_000);
        do_op(1'b0, 8'h5A, 0);
        chk("re_ins_hit", {last_hit, last_addr}, 4'b1_000);
        chk("re_ins_cnt", count, 1);

        do_reset();
        for (int k = 1; k <= 8; k++) do_op(1'b0, 8'(k), 0);
        chk("fill_cnt", count, 8);
        do_op(1'b0, 8'h09, 0);
`ifdef COMMON_DFFCAM_CTRL_REPLACE_EN
        chk("evict0", {last_full, last_addr}, 4'b0_000);
        do_op(1'b0, 8'h0A, 0);
        chk("evict1", {last_full, last_addr}, 4'b0_001);
`else
        chk("full_flag", {last_full, last_addr}, 4'b1_000);
`endif
        chk("full_cnt", count, 8);
        do_op(1'b1, 8'h03, 0);
        chk("rm_03", {last_hit, last_addr}, 4'b1_010);
        do_op(1'b0, 8'h77, 0);
        chk("ins_77", {last_hit, last_addr}, 4'b0_010);
        do_op(1'b1, 8'hEE, 5);
        chk("rm_miss", {last_hit, last_addr}, 4'b0_000);

        // Reset landing in WRITE must squash the write and the response.
        do_reset();
        req_valid = 1'b1; req_op = 1'b0; req_key = 8'h42;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_en", cam_en, 1);
        reset = 1'b1; #1;
        chk("rst_en_drop", cam_en, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_cnt", count, 0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_rsp", rsp_valid, 0);
        end
        chk("no_write", cv, 0);

        for (int n = 0; n < 150; n++)
            do_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), $urandom_range(0, 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
